// File: rtl/uart_pkg.sv
// Shared constants, state encoding and payload types for the record sender.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned NUM_CHARS        = 6;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned REC_W            = NUM_CHARS * BYTE_W;
  localparam int unsigned BIT_IDX_W        = 4;
  localparam int unsigned CHAR_CNT_W       = 3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Bit index of the stop bit within one 8N1 frame (0 start, 1-8 data, 9 stop)
  localparam logic [BIT_IDX_W-1:0] STOP_IDX = BIT_IDX_W'(9);

  typedef enum logic [1:0] {
    IDLE,
    XMIT,
    NEXT,
    DONE
  } state_t;

  typedef logic [REC_W-1:0] record_t;

endpackage

// File: rtl/record_sender_if.sv
// Handshake and serial-line bundle between a record producer and record_sender.
interface record_sender_if;
  import uart_pkg::*;

  logic    startSend;
  record_t record;
  logic    sendDone;
  logic    busy;
  logic    tx;

  modport master (output startSend, output record,
                  input  sendDone, input busy, input tx);
  modport slave  (input  startSend, input record,
                  output sendDone, output busy, output tx);
endinterface

// File: rtl/uart_tx_byte.sv
// One 8N1 UART frame per go; a go on the last stop-bit cycle chains the next frame.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [BYTE_W-1:0] data,
  output logic              tx,
  output logic              byteDone
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  =
    BAUD_W'((CLKS_PER_BIT >= 3) ? (CLKS_PER_BIT - 3) : 0);
  localparam bit SHORT_BIT = (CLKS_PER_BIT == 2);
  localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(BYTE_W);

  logic                 running;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [BYTE_W-1:0]    shreg;
  logic                 frame_end;
  logic                 pre_done;

  assign frame_end = (bit_idx == STOP_IDX) && (baud_cnt == BAUD_LAST);

  // byteDone lands on the second-to-last stop cycle so the next byte is ready on time
  assign pre_done = SHORT_BIT ? ((bit_idx == LAST_DATA_IDX) && (baud_cnt == BAUD_LAST))
                              : ((bit_idx == STOP_IDX) && (baud_cnt == BAUD_PRE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= STOP_BIT;
      byteDone <= 1'b0;
    end else begin
      byteDone <= running && pre_done;
      if (!running || frame_end) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
        if (go) begin
          running <= 1'b1;
          shreg   <= data;
          tx      <= START_BIT;
        end else begin
          running <= 1'b0;
          tx      <= STOP_BIT;
        end
      end else if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        bit_idx  <= bit_idx + BIT_IDX_W'(1);
        if (bit_idx == LAST_DATA_IDX) begin
          tx <= STOP_BIT;
        end else begin
          tx    <= shreg[0];
          shreg <= shreg >> 1;
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

endmodule

// File: rtl/record_sender.sv
// Serialises a six-character record as back-to-back 8N1 frames, first character first.
module record_sender #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF,
  parameter int unsigned NUM_CHARS    = uart_pkg::NUM_CHARS
) (
  input  logic            clk,
  input  logic            rst_n,
  record_sender_if.slave  bus
);
  import uart_pkg::*;

  localparam logic [CHAR_CNT_W-1:0] LAST_CHAR = CHAR_CNT_W'(NUM_CHARS - 1);

  state_t                state, state_d;
  record_t               shift, shift_d;
  logic [CHAR_CNT_W-1:0] char_cnt, char_cnt_d;
  logic                  busy, busy_d;
  logic                  send_done, send_done_d;
  logic                  go_c;
  logic [BYTE_W-1:0]     byte_c;
  logic                  byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      char_cnt  <= '0;
      busy      <= 1'b0;
      send_done <= 1'b0;
    end else begin
      state     <= state_d;
      shift     <= shift_d;
      char_cnt  <= char_cnt_d;
      busy      <= busy_d;
      send_done <= send_done_d;
    end
  end

  // NEXT overlaps the final stop-bit cycle, so it adds no line time
  always_comb begin
    state_d    = state;
    shift_d    = shift;
    char_cnt_d = char_cnt;
    go_c       = 1'b0;
    byte_c     = shift[REC_W-1 -: BYTE_W];
    unique case (state)
      IDLE: begin
        if (bus.startSend) begin
          shift_d    = bus.record;
          char_cnt_d = '0;
          state_d    = XMIT;
        end
      end
      XMIT: begin
        go_c = 1'b1;
        if (byte_done) state_d = NEXT;
      end
      NEXT: begin
        if (char_cnt == LAST_CHAR) begin
          state_d = DONE;
        end else begin
          go_c       = 1'b1;
          byte_c     = shift[REC_W-BYTE_W-1 -: BYTE_W];
          shift_d    = {shift[REC_W-BYTE_W-1:0], BYTE_W'(0)};
          char_cnt_d = char_cnt + CHAR_CNT_W'(1);
          state_d    = XMIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    send_done_d = (state_d == DONE);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go_c),
    .data     (byte_c),
    .tx       (bus.tx),
    .byteDone (byte_done)
  );

  assign bus.busy     = busy;
  assign bus.sendDone = send_done;

endmodule

// File: tb/tb_record_sender.sv
// Directed plus randomized bench for record_sender at 4 clocks per bit.
module tb_record_sender;

  localparam int CPB     = 4;
  localparam int REC_CYC = 60 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  record_sender_if bus();

  record_sender #(
    .CLKS_PER_BIT (CPB),
    .NUM_CHARS    (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk1("idle_tx", bus.tx, 1'b1);
      chk1("idle_busy", bus.busy, 1'b0);
      chk1("idle_done", bus.sendDone, 1'b0);
    end
  endtask

  // Expected line built from frame rules: per character start 0, data LSB first, stop 1.
  task automatic run_record(input logic [47:0] rec, input bit pokes, input bit corrupt,
                            input int abort_at, input bit start_at_done);
    logic       exp_bits[$];
    logic [7:0] exp_bytes[6];
    logic [7:0] dec[6];
    logic       tx_exp;
    int         pos;
    for (int c = 0; c < 6; c++) begin
      exp_bytes[c] = 8'(rec >> (8 * (5 - c)));
      for (int b = 0; b < 10; b++) begin
        logic v;
        v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_bytes[c][b-1];
        repeat (CPB) exp_bits.push_back(v);
      end
      dec[c] = 8'h00;
    end
    bus.startSend = 1'b1;
    bus.record    = rec;
    @(posedge clk); #1;
    for (int k = 0; k <= REC_CYC + 2; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk1("abort_tx", bus.tx, 1'b1);
        chk1("abort_busy", bus.busy, 1'b0);
        chk1("abort_done", bus.sendDone, 1'b0);
        repeat (2) begin
          @(posedge clk); #1;
          chk1("rst_tx", bus.tx, 1'b1);
          chk1("rst_done", bus.sendDone, 1'b0);
        end
        bus.startSend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      tx_exp = (k >= 1 && k <= REC_CYC) ? exp_bits[k-1] : 1'b1;
      chk1("tx", bus.tx, tx_exp);
      chk1("busy", bus.busy, (k <= REC_CYC + 1) ? 1'b1 : 1'b0);
      chk1("sendDone", bus.sendDone, (k == REC_CYC + 1) ? 1'b1 : 1'b0);
      if (k >= 1 && k <= REC_CYC && ((k - 1) % CPB) == CPB / 2) begin
        pos = (k - 1) / CPB;
        if ((pos % 10) >= 1 && (pos % 10) <= 8) dec[pos / 10][(pos % 10) - 1] = bus.tx;
      end
      bus.startSend = 1'b0;
      if (k == 0 && corrupt) bus.record = 48'hFFFF_FFFF_FFFF;
      if (pokes && (k == 50 || k == 120)) begin
        bus.startSend = 1'b1;
        bus.record    = {16'($urandom), $urandom};
      end
      if (start_at_done && k == REC_CYC + 1) begin
        bus.startSend = 1'b1;
        bus.record    = {16'($urandom), $urandom};
      end
    end
    for (int c = 0; c < 6; c++) chk8("decoded_byte", dec[c], exp_bytes[c]);
    bus.startSend = 1'b0;
  endtask

  initial begin
    bus.startSend = 1'b0;
    bus.record    = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_tx", bus.tx, 1'b1);
    chk1("reset_busy", bus.busy, 1'b0);
    chk1("reset_done", bus.sendDone, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_record(48'h41_42_43_44_45_46, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(2);
    run_record(48'h41_42_43_44_45_46, 1'b1, 1'b0, -1, 1'b0);
    idle_cycles(1);
    run_record(48'h41_42_43_44_45_46, 1'b0, 1'b1, -1, 1'b0);
    idle_cycles(1);
    // Abort inside the data bits of character 3, then accept on the first edge after release
    run_record(48'h41_42_43_44_45_46, 1'b0, 1'b0, 135, 1'b0);
    run_record(48'h41_42_43_44_45_46, 1'b0, 1'b0, -1, 1'b1);
    run_record({16'($urandom), $urandom}, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(1);
    run_record(48'h00_FF_55_AA_0D_0A, 1'b0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      run_record({16'($urandom), $urandom}, 1'($urandom), 1'($urandom), -1, 1'b0);
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
